// File: rtl/coherent_averager.sv
// Coherent point-by-point averager: accumulates 2^N excitation periods of two ADC channels
// into per-channel RAMs, then streams one averaged period out over a valid/ready interface.
module coherent_averager #(
    parameter int unsigned MAX_PTS = 1024,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned ACC_W   = 32
) (
    input  logic        CLK_65,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] ptos_x_ciclo,
    input  logic [4:0]  n_log2,
    input  logic [13:0] data_canal_a,
    input  logic [13:0] data_canal_b,
    input  logic        data_valid,
    output logic [13:0] avg_a,
    output logic [13:0] avg_b,
    output logic [15:0] avg_index,
    output logic        avg_valid,
    input  logic        avg_ready,
    output logic        busy,
    output logic        done,
    output logic        cfg_error
);

    typedef enum logic [2:0] {
        StIdle,
        StAccum,
        StDrain0,
        StDrain1,
        StRead
    } state_e;

    state_e state_q, state_d;

    // Latched run configuration
    logic [ADDR_W-1:0] p_last_q;
    logic [15:0]       cyc_last_q;
    logic [4:0]        n_q;
    logic              cfg_error_q;

    // Accumulation counters
    logic [ADDR_W-1:0] idx_q;
    logic [15:0]       cyc_q;

    // Read-modify-write stage 0 registers
    logic              s0_vld_q;
    logic              s0_first_q;
    logic [ADDR_W-1:0] s0_idx_q;
    logic [13:0]       s0_a_q;
    logic [13:0]       s0_b_q;

    // Readout
    logic [ADDR_W-1:0] out_idx_q;
    logic              avg_valid_q;
    logic              done_q;

    // Accumulator RAMs and their registered read ports
    logic [ACC_W-1:0]  ram_a [MAX_PTS];
    logic [ACC_W-1:0]  ram_b [MAX_PTS];
    logic [ACC_W-1:0]  rd_a_q;
    logic [ACC_W-1:0]  rd_b_q;
    logic [ADDR_W-1:0] raddr;

    logic              cfg_ok;
    logic              accept;
    logic              idx_wrap;
    logic              run_end;
    logic              handshake;
    logic              last_word;
    logic [ADDR_W-1:0] p_last_d;
    logic [15:0]       cyc_last_d;
    logic [ACC_W-1:0]  acc_a_nxt;
    logic [ACC_W-1:0]  acc_b_nxt;
    logic [ACC_W-1:0]  shifted_a;
    logic [ACC_W-1:0]  shifted_b;
    logic              unused_shift_bits;

    assign cfg_ok = (ptos_x_ciclo >= 16'd4) && (32'(ptos_x_ciclo) <= MAX_PTS) &&
                    (n_log2 <= 5'd16);
    assign p_last_d   = ADDR_W'(ptos_x_ciclo - 16'd1);
    assign cyc_last_d = 16'((17'd1 << n_log2) - 17'd1);

    assign accept    = (state_q == StAccum) && data_valid;
    assign idx_wrap  = (idx_q == p_last_q);
    assign run_end   = accept && idx_wrap && (cyc_q == cyc_last_q);
    assign handshake = avg_valid_q && avg_ready;
    assign last_word = (out_idx_q == p_last_q);

    // First period of a run overwrites whatever a previous run left in the RAM
    assign acc_a_nxt = (s0_first_q ? '0 : rd_a_q) + ACC_W'(s0_a_q);
    assign acc_b_nxt = (s0_first_q ? '0 : rd_b_q) + ACC_W'(s0_b_q);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK_65) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start && cfg_ok) state_d = StAccum;
            StAccum:  if (run_end) state_d = StDrain0;
            StDrain0: state_d = StDrain1;
            StDrain1: state_d = StRead;
            StRead:   if (handshake && last_word) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy  = (state_q != StIdle);
        raddr = '0;
        case (state_q)
            StAccum: raddr = idx_q;
            // Re-reading the presented address while stalled keeps the output word stable
            StRead:  raddr = handshake ? out_idx_q + 1'b1 : out_idx_q;
            default: raddr = '0;
        endcase
    end

    // ---------------- Control and counters ----------------
    always_ff @(posedge CLK_65) begin
        if (!reset_n) begin
            p_last_q    <= '0;
            cyc_last_q  <= '0;
            n_q         <= '0;
            cfg_error_q <= 1'b0;
            idx_q       <= '0;
            cyc_q       <= '0;
            s0_vld_q    <= 1'b0;
            out_idx_q   <= '0;
            avg_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            s0_vld_q <= accept;

            if ((state_q == StIdle) && start) begin
                if (cfg_ok) begin
                    p_last_q    <= p_last_d;
                    cyc_last_q  <= cyc_last_d;
                    n_q         <= n_log2;
                    cfg_error_q <= 1'b0;
                    idx_q       <= '0;
                    cyc_q       <= '0;
                end else begin
                    cfg_error_q <= 1'b1;
                end
            end

            if (accept) begin
                if (idx_wrap) begin
                    idx_q <= '0;
                    cyc_q <= cyc_q + 16'd1;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end

            // Address 0 is being read during DRAIN1, so its data is ready on entry to READ
            if (state_q == StDrain1) begin
                avg_valid_q <= 1'b1;
                out_idx_q   <= '0;
            end

            if ((state_q == StRead) && handshake) begin
                if (last_word) begin
                    avg_valid_q <= 1'b0;
                    out_idx_q   <= '0;
                    done_q      <= 1'b1;
                end else begin
                    out_idx_q <= out_idx_q + 1'b1;
                end
            end
        end
    end

    // ---------------- Stage 0 data (no reset needed) ----------------
    always_ff @(posedge CLK_65) begin
        if (accept) begin
            s0_idx_q   <= idx_q;
            s0_first_q <= (cyc_q == 16'd0);
            s0_a_q     <= data_canal_a;
            s0_b_q     <= data_canal_b;
        end
    end

    // ---------------- Accumulator RAMs ----------------
    always_ff @(posedge CLK_65) begin
        if (s0_vld_q) begin
            ram_a[s0_idx_q] <= acc_a_nxt;
            ram_b[s0_idx_q] <= acc_b_nxt;
        end
        rd_a_q <= ram_a[raddr];
        rd_b_q <= ram_b[raddr];
    end

    // ---------------- Output formatting ----------------
    assign shifted_a = rd_a_q >> n_q;
    assign shifted_b = rd_b_q >> n_q;
    assign unused_shift_bits = ^{shifted_a[ACC_W-1:14], shifted_b[ACC_W-1:14]};

    assign avg_a     = avg_valid_q ? shifted_a[13:0] : 14'd0;
    assign avg_b     = avg_valid_q ? shifted_b[13:0] : 14'd0;
    assign avg_index = 16'(out_idx_q);
    assign avg_valid = avg_valid_q;
    assign done      = done_q;
    assign cfg_error = cfg_error_q;

endmodule

// File: tb/tb_coherent_averager.sv
// Randomized bench for coherent_averager: a sum-per-index model predicts every output word.
module tb_coherent_averager;

    logic        CLK_65 = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] ptos_x_ciclo = 16'd8;
    logic [4:0]  n_log2 = 5'd0;
    logic [13:0] data_canal_a = 14'd0;
    logic [13:0] data_canal_b = 14'd0;
    logic        data_valid = 1'b0;
    logic [13:0] avg_a;
    logic [13:0] avg_b;
    logic [15:0] avg_index;
    logic        avg_valid;
    logic        avg_ready = 1'b1;
    logic        busy;
    logic        done;
    logic        cfg_error;

    coherent_averager dut (
        .CLK_65       (CLK_65),
        .reset_n      (reset_n),
        .start        (start),
        .ptos_x_ciclo (ptos_x_ciclo),
        .n_log2       (n_log2),
        .data_canal_a (data_canal_a),
        .data_canal_b (data_canal_b),
        .data_valid   (data_valid),
        .avg_a        (avg_a),
        .avg_b        (avg_b),
        .avg_index    (avg_index),
        .avg_valid    (avg_valid),
        .avg_ready    (avg_ready),
        .busy         (busy),
        .done         (done),
        .cfg_error    (cfg_error)
    );

    always #5 CLK_65 = ~CLK_65;

    typedef struct {
        int idx;
        longint a;
        longint b;
    } word_t;

    word_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    lit_mode = 0;
    int    lit_a = 0;
    int    lit_b = 0;
    int    ready_mode = 0;
    bit    expect_done = 1'b0;
    bit    done_seen = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Output scoreboard: every cycle with a word on the bus is compared to the model
    always @(negedge CLK_65) begin
        if (reset_n) begin
            if (expect_done) begin
                check("done_pulse", longint'(done), 1);
                expect_done = 1'b0;
                done_seen   = 1'b1;
            end else if (done) begin
                check("spurious_done", longint'(done), 0);
            end
            if (avg_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", longint'(avg_valid), 0);
                end else begin
                    check("avg_index", longint'(avg_index), exp_q[0].idx);
                    check("avg_a", longint'(avg_a), exp_q[0].a);
                    check("avg_b", longint'(avg_b), exp_q[0].b);
                    if (lit_mode == 1) begin
                        check("lit_a", longint'(avg_a), lit_a);
                        check("lit_b", longint'(avg_b), lit_b);
                    end else if (lit_mode == 2) begin
                        check("ramp_a", longint'(avg_a), avg_index * 100 + 1);
                        check("ramp_b", longint'(avg_b), 16383 - avg_index * 100 - 2);
                    end
                    if (avg_ready) begin
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) expect_done = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge CLK_65);
            #1;
            case (ready_mode)
                0:       avg_ready = 1'b1;
                1:       avg_ready = ~avg_ready;
                default: avg_ready = 1'($urandom_range(1));
            endcase
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic do_start(input int p, input int n);
        @(posedge CLK_65);
        #1;
        start        = 1'b1;
        ptos_x_ciclo = p[15:0];
        n_log2       = n[4:0];
        data_valid   = 1'b0;
        @(posedge CLK_65);
        #1;
        start = 1'b0;
    endtask

    // smode: 0 constant (ca, cb), 1 ramp idx*100+cyc, 2 random
    task automatic run(input int p, input int n, input int smode, input int ca, input int cb,
                       input int gap_pct, input bit glitch, input int abort_at);
        longint sa[];
        longint sb[];
        int     total;
        int     k;
        int     a;
        int     b;
        bit     aborted;
        word_t  w;
        sa = new[p];
        sb = new[p];
        total = p << n;
        k = 0;
        aborted = 1'b0;
        done_seen = 1'b0;
        do_start(p, n);
        while (k < total) begin
            if (abort_at >= 0 && k == abort_at) begin
                aborted = 1'b1;
                break;
            end
            if (int'($urandom_range(99)) < gap_pct) begin
                data_valid   = 1'b0;
                data_canal_a = 14'($urandom);
                data_canal_b = 14'($urandom);
            end else begin
                case (smode)
                    0: begin a = ca; b = cb; end
                    1: begin a = (k % p) * 100 + k / p; b = 16383 - a; end
                    default: begin a = int'($urandom_range(16383)); b = int'($urandom_range(16383)); end
                endcase
                data_valid   = 1'b1;
                data_canal_a = a[13:0];
                data_canal_b = b[13:0];
                sa[k % p] += a;
                sb[k % p] += b;
                k++;
            end
            start = glitch && (k == 50);
            if (glitch) ptos_x_ciclo = 16'd5;
            @(posedge CLK_65);
            #1;
        end
        data_valid = 1'b0;
        start      = 1'b0;
        if (!aborted) begin
            for (int i = 0; i < p; i++) begin
                w.idx = i;
                w.a   = sa[i] >> n;
                w.b   = sb[i] >> n;
                exp_q.push_back(w);
            end
            // Samples and start pulses during drain/readout must be ignored
            for (int j = 0; j < 3; j++) begin
                data_valid   = 1'b1;
                data_canal_a = 14'($urandom);
                data_canal_b = 14'($urandom);
                start        = glitch;
                @(posedge CLK_65);
                #1;
            end
            data_valid = 1'b0;
            start      = 1'b0;
        end
    endtask

    task automatic wait_done(input string name);
        int cnt;
        cnt = 0;
        while (!done_seen && cnt < 5000) begin
            @(posedge CLK_65);
            cnt++;
        end
        check({name, "_done_seen"}, longint'(done_seen), 1);
        @(negedge CLK_65);
        check({name, "_busy_after"}, longint'(busy), 0);
        check({name, "_valid_after"}, longint'(avg_valid), 0);
        check({name, "_words_left"}, exp_q.size(), 0);
        exp_q.delete();
        done_seen = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge CLK_65);
        #1;
        reset_n = 1'b1;
        @(negedge CLK_65);
        check("rst_busy", longint'(busy), 0);
        check("rst_valid", longint'(avg_valid), 0);
        check("rst_done", longint'(done), 0);
        check("rst_cfg_error", longint'(cfg_error), 0);
        check("rst_avg_a", longint'(avg_a), 0);
        check("rst_avg_b", longint'(avg_b), 0);
        check("rst_avg_index", longint'(avg_index), 0);

        // Constant input
        ready_mode = 0; lit_mode = 1; lit_a = 8192; lit_b = 100;
        run(8, 2, 0, 8192, 100, 0, 1'b0, -1);
        wait_done("const");
        check("const_cfg_error", longint'(cfg_error), 0);

        // Ramp input
        lit_mode = 2;
        run(16, 2, 1, 0, 0, 0, 1'b0, -1);
        wait_done("ramp");

        // Ramp with input gaps and a toggling ready
        ready_mode = 1;
        run(16, 2, 1, 0, 0, 50, 1'b0, -1);
        wait_done("ramp_gaps");

        // Illegal configurations
        lit_mode = 0; ready_mode = 2;
        do_start(3, 2);
        @(negedge CLK_65);
        check("p3_cfg_error", longint'(cfg_error), 1);
        check("p3_busy", longint'(busy), 0);
        do_start(1025, 0);
        @(negedge CLK_65);
        check("p1025_cfg_error", longint'(cfg_error), 1);
        do_start(8, 17);
        @(negedge CLK_65);
        check("n17_cfg_error", longint'(cfg_error), 1);
        check("n17_busy", longint'(busy), 0);
        repeat (5) @(posedge CLK_65);
        run(4, 0, 2, 0, 0, 20, 1'b0, -1);
        check("legal_cfg_error", longint'(cfg_error), 0);
        wait_done("p4n0");

        // Reset in the middle of a run, then a fresh run over stale RAM
        ready_mode = 0;
        run(8, 4, 0, 5000, 5000, 0, 1'b0, 2 * 8 + 3);
        reset_n = 1'b0;
        @(posedge CLK_65);
        #1;
        reset_n = 1'b1;
        exp_q.delete();
        expect_done = 1'b0;
        @(negedge CLK_65);
        check("midrst_busy", longint'(busy), 0);
        check("midrst_valid", longint'(avg_valid), 0);
        check("midrst_avg_a", longint'(avg_a), 0);
        lit_mode = 1; lit_a = 1234; lit_b = 1234;
        run(8, 1, 0, 1234, 1234, 0, 1'b0, -1);
        wait_done("after_rst");

        // N=16 is a legal configuration
        do_start(4, 16);
        @(negedge CLK_65);
        check("n16_cfg_error", longint'(cfg_error), 0);
        check("n16_busy", longint'(busy), 1);
        @(posedge CLK_65);
        #1;
        reset_n = 1'b0;
        @(posedge CLK_65);
        #1;
        reset_n = 1'b1;

        // Full-scale input with start pulses during accumulate and readout
        lit_a = 16383; lit_b = 16383;
        run(4, 12, 0, 16383, 16383, 0, 1'b1, -1);
        wait_done("fullscale");

        // Maximum period length, random data, gaps and random ready
        lit_mode = 0; ready_mode = 2;
        run(1024, 1, 2, 0, 0, 25, 1'b0, -1);
        wait_done("maxpts");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
